// File: rtl/goldschmidt_ctrl_if.sv
// Request/response bundle between the divide requester and goldschmidt_ctrl.
interface goldschmidt_ctrl_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic       div_by_zero;

  modport master (output start, a, b, input busy, done, q, div_by_zero);
  modport slave  (input start, a, b, output busy, done, q, div_by_zero);
endinterface

// File: rtl/goldschmidt_ctrl.sv
// Goldschmidt division sequencer for the 8-bit minifloat (s|eeee|mmm, bias 7).
// Latches the operands, builds the reciprocal seed, then steps an external
// combinational multiply datapath ITER times, capturing N/D/F each iteration.
module goldschmidt_ctrl #(
  parameter int ITER   = 3,
  parameter int DP_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  goldschmidt_ctrl_if.slave req,
  output logic [7:0]        dp_n,
  output logic [7:0]        dp_d,
  output logic [7:0]        dp_f,
  input  logic [7:0]        dp_n_out,
  input  logic [7:0]        dp_d_out,
  input  logic [7:0]        dp_f_out
);
  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;

  localparam logic [2:0] ITER_LAST = 3'(ITER - 1);
  localparam logic [1:0] PH_LAST   = 2'(DP_LAT);

  state_t     state;
  logic       sgn;
  logic [7:0] n_r, d_r, f_r;
  logic [2:0] iter_cnt;
  logic [1:0] phase;
  logic       busy_r, done_r, dbz_r;
  logic [7:0] q_r;

  logic [3:0] seed_e;
  logic [2:0] seed_m;
  logic [2:0] seed_man;
  logic [3:0] seed_exp;
  logic       seed_uf;

  // Reciprocal seed from the latched divisor. The seed exponent is 14-e for an
  // exact power of two and 13-e otherwise; it drops below 1 exactly when
  // e >= 14 (m == 0) or e >= 13 (m != 0), which is the underflow flush.
  always_comb begin
    seed_e = d_r[6:3];
    seed_m = d_r[2:0];
    case (seed_m)
      3'd0:    seed_man = 3'd0;
      3'd1:    seed_man = 3'd6;
      3'd2:    seed_man = 3'd5;
      3'd3:    seed_man = 3'd4;
      3'd4:    seed_man = 3'd3;
      3'd5:    seed_man = 3'd2;
      default: seed_man = 3'd1;
    endcase
    seed_exp = (seed_m == 3'd0) ? (4'd14 - seed_e) : (4'd13 - seed_e);
    seed_uf  = (seed_m == 3'd0) ? (seed_e >= 4'd14) : (seed_e >= 4'd13);
  end

  // Control FSM with registered status outputs and the N/D/F iteration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sgn      <= 1'b0;
      n_r      <= '0;
      d_r      <= '0;
      f_r      <= '0;
      iter_cnt <= '0;
      phase    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      q_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (req.start) begin
            sgn    <= req.a[7] ^ req.b[7];
            n_r    <= {1'b0, req.a[6:0]};
            d_r    <= {1'b0, req.b[6:0]};
            busy_r <= 1'b1;
            state  <= SEED;
          end
        end
        SEED: begin
          if (d_r[6:3] == 4'd0) begin
            q_r    <= {sgn, 7'h78};
            dbz_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= DONE;
          end else if (n_r[6:3] == 4'd0 || seed_uf) begin
            q_r    <= {sgn, 7'h00};
            dbz_r  <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            f_r      <= {1'b0, seed_exp, seed_man};
            iter_cnt <= '0;
            phase    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Operands stay put for DP_LAT+1 cycles; capture on the last one.
          if (phase == PH_LAST) begin
            n_r      <= {1'b0, dp_n_out[6:0]};
            d_r      <= {1'b0, dp_d_out[6:0]};
            f_r      <= {1'b0, dp_f_out[6:0]};
            phase    <= '0;
            iter_cnt <= iter_cnt + 3'd1;
            if (iter_cnt == ITER_LAST) begin
              q_r    <= {sgn, dp_n_out[6:0]};
              dbz_r  <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end
          end else begin
            phase <= phase + 2'd1;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req.busy        = busy_r;
  assign req.done        = done_r;
  assign req.q           = q_r;
  assign req.div_by_zero = dbz_r;
  assign dp_n            = n_r;
  assign dp_d            = d_r;
  assign dp_f            = f_r;
endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Bench: two controllers (DP_LAT=0 and DP_LAT=2) share stimulus; each drives
// its own behavioural minifloat datapath. A value-level reference model gives
// the expected per-iteration operands, quotient and latency.
module tb_goldschmidt_ctrl;
  localparam int ITER = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] a_s, b_s;
  logic [7:0] dp_n0, dp_d0, dp_f0, dp_n_out0, dp_d_out0, dp_f_out0;
  logic [7:0] dp_n1, dp_d1, dp_f1, dp_n_out1, dp_d_out1, dp_f_out1;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_q;
  logic [7:0] mn [0:ITER];
  logic [7:0] md [0:ITER];
  logic [7:0] mf [0:ITER];

  always #5 clk = ~clk;

  goldschmidt_ctrl_if if0 ();
  goldschmidt_ctrl_if if1 ();
  assign if0.start = start0;
  assign if1.start = start1;
  assign if0.a = a_s;
  assign if0.b = b_s;
  assign if1.a = a_s;
  assign if1.b = b_s;

  goldschmidt_ctrl #(.ITER(ITER), .DP_LAT(0)) u0 (
    .clk(clk), .rst(rst), .req(if0),
    .dp_n(dp_n0), .dp_d(dp_d0), .dp_f(dp_f0),
    .dp_n_out(dp_n_out0), .dp_d_out(dp_d_out0), .dp_f_out(dp_f_out0));

  goldschmidt_ctrl #(.ITER(ITER), .DP_LAT(2)) u1 (
    .clk(clk), .rst(rst), .req(if1),
    .dp_n(dp_n1), .dp_d(dp_d1), .dp_f(dp_f1),
    .dp_n_out(dp_n_out1), .dp_d_out(dp_d_out1), .dp_f_out(dp_f_out1));

  // Minifloat value as fixed point scaled by 2^20; exponent 0 means zero.
  function automatic logic [63:0] to_fix(input logic [7:0] x);
    if (x[6:3] == 4'd0) return 64'd0;
    return 64'(8 + int'(x[2:0])) << (int'(x[6:3]) + 10);
  endfunction

  // Back to minifloat, truncating the mantissa; flush below 2^-6, saturate above.
  function automatic logic [7:0] from_fix(input logic [63:0] v);
    int p, e;
    p = -1;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    if (p < 0) return 8'h00;
    e = p - 13;
    if (e < 1) return 8'h00;
    if (e > 15) return 8'h7f;
    return {1'b0, 4'(e), 3'(v >> (p - 3))};
  endfunction

  function automatic logic [7:0] fmul(input logic [7:0] x, input logic [7:0] y);
    return from_fix((to_fix(x) * to_fix(y)) >> 20);
  endfunction

  function automatic logic [7:0] ftm(input logic [7:0] x);
    logic [63:0] v;
    v = to_fix(x);
    if (v >= 64'h20_0000) return 8'h00;
    return from_fix(64'h20_0000 - v);
  endfunction

  assign dp_n_out0 = fmul(dp_n0, dp_f0);
  assign dp_d_out0 = fmul(dp_d0, dp_f0);
  assign dp_f_out0 = ftm(fmul(dp_d0, dp_f0));
  assign dp_n_out1 = fmul(dp_n1, dp_f1);
  assign dp_d_out1 = fmul(dp_d1, dp_f1);
  assign dp_f_out1 = ftm(fmul(dp_d1, dp_f1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient, zero-divide flag, special-case flag and the N/D/F
  // values the datapath should see at the start of each iteration.
  task automatic model(input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] rq, output logic rdbz, output bit sp);
    int lut [8] = '{0, 6, 5, 4, 3, 2, 1, 1};
    int e, se;
    logic s;
    s = av[7] ^ bv[7];
    e = int'(bv[6:3]);
    se = (bv[2:0] == 3'd0) ? 14 - e : 13 - e;
    rdbz = 1'b0;
    sp = 1'b1;
    rq = {s, 7'h00};
    if (e == 0) begin
      rq = {s, 7'h78};
      rdbz = 1'b1;
    end else if (av[6:3] != 4'd0 && se >= 1) begin
      sp = 1'b0;
      mn[0] = {1'b0, av[6:0]};
      md[0] = {1'b0, bv[6:0]};
      mf[0] = {1'b0, 4'(se), 3'(lut[bv[2:0]])};
      for (int i = 0; i < ITER; i++) begin
        mn[i+1] = fmul(mn[i], mf[i]);
        md[i+1] = fmul(md[i], mf[i]);
        mf[i+1] = ftm(fmul(md[i], mf[i]));
      end
      rq = {s, mn[ITER][6:0]};
    end
  endtask

  // One operation on both controllers, optionally pulsing start while busy.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input bit pulse);
    logic [7:0] rq;
    logic rdbz;
    bit sp, pl;
    int lat0, lat1, dc0, dc1, nd0, nd1, it;
    model(av, bv, rq, rdbz, sp);
    lat0 = sp ? 2 : 2 + ITER;
    lat1 = sp ? 2 : 2 + ITER * 3;
    pl = pulse && !sp;
    dc0 = 0; dc1 = 0; nd0 = 0; nd1 = 0;
    @(negedge clk);
    a_s = av; b_s = bv; start0 = 1'b1; start1 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start0 = pl && (k == 3 || k == lat0);
      start1 = pl && (k == 3 || k == lat1);
      if (k == 1) begin
        chk("q_hold0", 32'(if0.q), 32'(prev_q));
        chk("q_hold1", 32'(if1.q), 32'(prev_q));
      end
      chk("busy0", 32'(if0.busy), 32'(k <= lat0));
      chk("busy1", 32'(if1.busy), 32'(k <= lat1));
      if (if0.done) begin
        nd0++;
        if (dc0 == 0) begin
          dc0 = k;
          chk("q0", 32'(if0.q), 32'(rq));
          chk("dbz0", 32'(if0.div_by_zero), 32'(rdbz));
        end
      end
      if (if1.done) begin
        nd1++;
        if (dc1 == 0) begin
          dc1 = k;
          chk("q1", 32'(if1.q), 32'(rq));
          chk("dbz1", 32'(if1.div_by_zero), 32'(rdbz));
        end
      end
      if (!sp && k >= 2 && k < lat0) begin
        it = k - 2;
        chk("dp_n0", 32'(dp_n0), 32'(mn[it]));
        chk("dp_d0", 32'(dp_d0), 32'(md[it]));
        chk("dp_f0", 32'(dp_f0), 32'(mf[it]));
      end
      if (!sp && k >= 2 && k < lat1) begin
        it = (k - 2) / 3;
        chk("dp_n1", 32'(dp_n1), 32'(mn[it]));
        chk("dp_d1", 32'(dp_d1), 32'(md[it]));
        chk("dp_f1", 32'(dp_f1), 32'(mf[it]));
      end
    end
    chk("done_cyc0", 32'(dc0), 32'(lat0));
    chk("done_cyc1", 32'(dc1), 32'(lat1));
    chk("done_cnt0", 32'(nd0), 32'd1);
    chk("done_cnt1", 32'(nd1), 32'd1);
    chk("q_idle0", 32'(if0.q), 32'(rq));
    chk("dbz_idle1", 32'(if1.div_by_zero), 32'(rdbz));
    prev_q = rq;
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; a_s = '0; b_s = '0; prev_q = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy0", 32'(if0.busy), 32'd0);
    chk("rst_done0", 32'(if0.done), 32'd0);
    chk("rst_q1", 32'(if1.q), 32'd0);
    chk("rst_dbz1", 32'(if1.div_by_zero), 32'd0);
    chk("rst_dp0", 32'({dp_n0, dp_d0, dp_f0}), 32'd0);
    rst = 1'b0;

    // Directed cases
    do_op(8'h40, 8'h40, 1'b0);
    chk("q_2div2", 32'(if0.q), 32'h38);
    do_op(8'hC8, 8'h40, 1'b0);
    chk("q_neg_sign", 32'(if1.q[7]), 32'd1);
    do_op(8'h40, 8'h05, 1'b0);
    chk("q_dbz", 32'(if0.q), 32'h78);
    chk("dbz_set", 32'(if0.div_by_zero), 32'd1);
    do_op(8'h00, 8'h40, 1'b0);
    chk("q_zero_a", 32'(if0.q), 32'h00);
    do_op(8'h40, 8'h78, 1'b0);
    chk("q_uflow", 32'(if1.q), 32'h00);
    do_op(8'hC0, 8'h78, 1'b0);
    chk("q_uflow_neg", 32'(if0.q), 32'h80);
    do_op(8'h4B, 8'h3D, 1'b1);

    // Reset in the middle of an operation
    @(negedge clk);
    a_s = 8'h50; b_s = 8'h3A; start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_done0", 32'(if0.done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy0", 32'(if0.busy), 32'd0);
    chk("abort_busy1", 32'(if1.busy), 32'd0);
    chk("abort_q0", 32'(if0.q), 32'd0);
    chk("abort_q1", 32'(if1.q), 32'd0);
    chk("abort_done1", 32'(if1.done), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_nodone0", 32'(if0.done), 32'd0);
      chk("abort_nodone1", 32'(if1.done), 32'd0);
    end
    prev_q = 8'h00;
    do_op(8'h50, 8'h3A, 1'b0);

    // Randomized operands, mostly in the normal-result range
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
      end else begin
        ra = {1'($urandom), 4'($urandom_range(1, 15)), 3'($urandom)};
        rb = {1'($urandom), 4'($urandom_range(1, 12)), 3'($urandom)};
      end
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
